booth_mac_accum: RTL and testbench

- Downstream of the 4x4 radix-4 Booth multiplier.
- Samples each 8-bit signed product when the multiplier's done strobe pulses, and accumulates N_TERMS consecutive products into a wide signed sum (dot-product / MAC stage).
- Presents the completed sum on a valid/ready output handshake.
- A one-entry pending register absorbs a product that arrives while the previous result is still unacknowledged.

---
 rtl/booth_pkg.sv | 10 +
 rtl/booth_sat_add.sv | 28 ++
 rtl/booth_mac_accum.sv | 165 ++++++++++++++++
 tb/tb_booth_mac_accum.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and constants for the Booth product accumulate stage
package booth_pkg;

  localparam int PROD_W = 8;

  typedef enum logic {ACCUM, HOLD} acc_state_t;

  typedef logic signed [PROD_W-1:0] prod_t;

endpackage

// File: rtl/booth_sat_add.sv
// rtl/booth_sat_add.sv - signed W-bit adder with overflow flag, clamps under BOOTH_ACC_SAT_EN
module booth_sat_add #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] sum_o,
  output logic                ovf_o
);

  logic signed [W-1:0] raw;

  // Overflow only when both operands share a sign and the result's sign differs
  always_comb begin
    raw   = a_i + b_i;
    ovf_o = (a_i[W-1] == b_i[W-1]) && (raw[W-1] != a_i[W-1]);
`ifdef BOOTH_ACC_SAT_EN
    if (ovf_o) begin
      sum_o = a_i[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sum_o = raw;
    end
`else
    sum_o = raw;
`endif
  end

endmodule

// File: rtl/booth_mac_accum.sv
// rtl/booth_mac_accum.sv - accumulates N_TERMS Booth products per result; saturation under BOOTH_ACC_SAT_EN
module booth_mac_accum
  import booth_pkg::*;
#(
  parameter int ACC_W   = 16,
  parameter int N_TERMS = 4,
  localparam int CNT_W  = $clog2(N_TERMS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  prod_t                   mult_y,
  input  logic                    booth_done,
  input  logic                    acc_clr,
  output logic signed [ACC_W-1:0] acc_y,
  output logic                    acc_valid,
  input  logic                    acc_ready,
  output logic [CNT_W-1:0]        term_cnt,
  output logic                    ovf,
  output logic                    drop_err
);

  acc_state_t              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] acc_y_q, acc_y_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  prod_t                   pend_q, pend_d;
  logic                    pend_vld_q, pend_vld_d;
  logic                    valid_q, valid_d;
  logic                    ovf_q, ovf_d;
  logic                    drop_q, drop_d;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] pend_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic                    acc_ovf;
  logic signed [ACC_W-1:0] restart_sum;
  logic                    restart_ovf;
  logic                    handshake;

  assign prod_ext  = {{(ACC_W-PROD_W){mult_y[PROD_W-1]}}, mult_y};
  assign pend_ext  = {{(ACC_W-PROD_W){pend_q[PROD_W-1]}}, pend_q};
  assign handshake = valid_q && acc_ready;

  // Running sum plus the incoming product
  booth_sat_add #(.W(ACC_W)) u_acc_add (
    .a_i   (acc_q),
    .b_i   (prod_ext),
    .sum_o (acc_sum),
    .ovf_o (acc_ovf)
  );

  // Seeds the next group when a parked product and a fresh one meet at the handshake
  booth_sat_add #(.W(ACC_W)) u_restart_add (
    .a_i   (pend_ext),
    .b_i   (prod_ext),
    .sum_o (restart_sum),
    .ovf_o (restart_ovf)
  );

  // Next-state: clear dominates, then accumulate, or hold/park/restart around the handshake
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    acc_y_d    = acc_y_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;
    drop_d     = drop_q;

    if (acc_clr) begin
      state_d    = ACCUM;
      acc_d      = '0;
      acc_y_d    = '0;
      cnt_d      = '0;
      pend_d     = '0;
      pend_vld_d = 1'b0;
      valid_d    = 1'b0;
      ovf_d      = 1'b0;
      drop_d     = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (booth_done) begin
            if (acc_ovf) ovf_d = 1'b1;
            if (cnt_q == CNT_W'(N_TERMS - 1)) begin
              acc_y_d = acc_sum;
              valid_d = 1'b1;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = HOLD;
            end else begin
              acc_d = acc_sum;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (handshake) begin
            valid_d    = 1'b0;
            ovf_d      = 1'b0;
            state_d    = ACCUM;
            pend_vld_d = 1'b0;
            pend_d     = '0;
            if (pend_vld_q && booth_done) begin
              acc_d = restart_sum;
              cnt_d = CNT_W'(2);
              ovf_d = restart_ovf;
            end else if (pend_vld_q) begin
              acc_d = pend_ext;
              cnt_d = CNT_W'(1);
            end else if (booth_done) begin
              acc_d = prod_ext;
              cnt_d = CNT_W'(1);
            end else begin
              acc_d = '0;
              cnt_d = '0;
            end
          end else if (booth_done) begin
            if (pend_vld_q) begin
              drop_d = 1'b1;
            end else begin
              pend_d     = mult_y;
              pend_vld_d = 1'b1;
            end
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      acc_y_q    <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      acc_y_q    <= acc_y_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end

  assign acc_y     = acc_y_q;
  assign acc_valid = valid_q;
  assign term_cnt  = cnt_q;
  assign ovf       = ovf_q;
  assign drop_err  = drop_q;

endmodule

// File: tb/tb_booth_mac_accum.sv
// tb/tb_booth_mac_accum.sv - scoreboard bench for booth_mac_accum
module tb_booth_mac_accum;

  logic        clk = 1'b0;
  logic        rst;

  logic [7:0]  mult_y;
  logic        booth_done;
  logic        acc_clr;
  logic [15:0] acc_y;
  logic        acc_valid;
  logic        acc_ready;
  logic [2:0]  term_cnt;
  logic        ovf;
  logic        drop_err;

  logic [7:0]  mult_y1;
  logic        booth_done1;
  logic        acc_clr1;
  logic [8:0]  acc_y1;
  logic        acc_valid1;
  logic        acc_ready1;
  logic [2:0]  term_cnt1;
  logic        ovf1;
  logic        drop_err1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] y;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  booth_mac_accum #(.ACC_W(16), .N_TERMS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mult_y     (mult_y),
    .booth_done (booth_done),
    .acc_clr    (acc_clr),
    .acc_y      (acc_y),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .term_cnt   (term_cnt),
    .ovf        (ovf),
    .drop_err   (drop_err)
  );

  booth_mac_accum #(.ACC_W(9), .N_TERMS(4)) dut9 (
    .clk        (clk),
    .rst        (rst),
    .mult_y     (mult_y1),
    .booth_done (booth_done1),
    .acc_clr    (acc_clr1),
    .acc_y      (acc_y1),
    .acc_valid  (acc_valid1),
    .acc_ready  (acc_ready1),
    .term_cnt   (term_cnt1),
    .ovf        (ovf1),
    .drop_err   (drop_err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] y);
    @(posedge clk);
    #1;
    mult_y     = y;
    booth_done = 1'b1;
    @(posedge clk);
    #1;
    booth_done = 1'b0;
  endtask

  task automatic strobe9(input logic [7:0] y);
    @(posedge clk);
    #1;
    mult_y1     = y;
    booth_done1 = 1'b1;
    @(posedge clk);
    #1;
    booth_done1 = 1'b0;
  endtask

  // Monitor: every accepted result is compared against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && acc_valid && acc_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got acc_y=%04h with empty scoreboard", acc_y);
        end else begin
          e = exp_q.pop_front();
          if (acc_y !== e.y || ovf !== e.ovf) begin
            errors++;
            $display("FAIL result: got acc_y=%04h ovf=%0b expected acc_y=%04h ovf=%0b",
                     acc_y, ovf, e.y, e.ovf);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    mult_y = '0; booth_done = 1'b0; acc_clr = 1'b0; acc_ready = 1'b1;
    mult_y1 = '0; booth_done1 = 1'b0; acc_clr1 = 1'b0; acc_ready1 = 1'b1;
    idle(2);
    chk("rst_acc_y", 32'(acc_y), 32'h0);
    chk("rst_valid", 32'(acc_valid), 32'h0);
    chk("rst_term_cnt", 32'(term_cnt), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_drop", 32'(drop_err), 32'h0);
    rst = 1'b1;
    idle(2);

    // 1. basic sum 6 - 15 + 64 + 1 = 56
    strobe(8'h06);
    chk("t1_cnt1", 32'(term_cnt), 32'd1);
    idle(4);
    strobe(8'hF1); idle(4);
    strobe(8'h40); idle(4);
    exp_q.push_back('{y: 16'h0038, ovf: 1'b0});
    strobe(8'h01);
    chk("t1_valid_latency", 32'(acc_valid), 32'h1);
    chk("t1_cnt_wrap", 32'(term_cnt), 32'd0);
    chk("t1_ovf", 32'(ovf), 32'h0);
    idle(4);
    chk("t1_valid_drop", 32'(acc_valid), 32'h0);

    // 2. stall: 1+2+3+4 = 10 held, 0x0A parked, then 10+1+1+1 = 13
    acc_ready = 1'b0;
    strobe(8'h01); idle(4);
    strobe(8'h02); idle(4);
    strobe(8'h03); idle(4);
    exp_q.push_back('{y: 16'h000A, ovf: 1'b0});
    strobe(8'h04); idle(4);
    strobe(8'h0A); idle(4);
    chk("t2_y_stable", 32'(acc_y), 32'h000A);
    chk("t2_valid_held", 32'(acc_valid), 32'h1);
    chk("t2_no_drop", 32'(drop_err), 32'h0);
    acc_ready = 1'b1;
    idle(1);
    chk("t2_cnt_from_pend", 32'(term_cnt), 32'd1);
    idle(3);
    strobe(8'h01); idle(4);
    strobe(8'h01); idle(4);
    exp_q.push_back('{y: 16'h000D, ovf: 1'b0});
    strobe(8'h01); idle(4);

    // 3. drop: 2*4 = 8 held, two strobes in HOLD, the second is lost
    acc_ready = 1'b0;
    strobe(8'h02); idle(4);
    strobe(8'h02); idle(4);
    strobe(8'h02); idle(4);
    exp_q.push_back('{y: 16'h0008, ovf: 1'b0});
    strobe(8'h02); idle(4);
    strobe(8'h11); idle(4);
    chk("t3_drop_first", 32'(drop_err), 32'h0);
    strobe(8'h22); idle(4);
    chk("t3_drop_second", 32'(drop_err), 32'h1);
    chk("t3_y_unchanged", 32'(acc_y), 32'h0008);
    acc_ready = 1'b1;
    idle(1);
    chk("t3_cnt_restart", 32'(term_cnt), 32'd1);
    idle(3);
    strobe(8'h01); idle(4);
    chk("t6_cnt_before_clr", 32'(term_cnt), 32'd2);

    // 6a. clear with a simultaneous strobe
    mult_y = 8'h7F; booth_done = 1'b1; acc_clr = 1'b1;
    idle(1);
    booth_done = 1'b0; acc_clr = 1'b0;
    chk("t6_clr_cnt", 32'(term_cnt), 32'd0);
    chk("t6_clr_drop", 32'(drop_err), 32'h0);
    chk("t6_clr_acc_y", 32'(acc_y), 32'h0);
    chk("t6_clr_valid", 32'(acc_valid), 32'h0);
    idle(4);

    // 4. pend 0x05 meets new 0x03 at the handshake; accumulator starts from 0 after clear
    acc_ready = 1'b0;
    strobe(8'h01); idle(4);
    strobe(8'h01); idle(4);
    strobe(8'h01); idle(4);
    exp_q.push_back('{y: 16'h0004, ovf: 1'b0});
    strobe(8'h01); idle(4);
    strobe(8'h05); idle(4);
    mult_y = 8'h03; booth_done = 1'b1; acc_ready = 1'b1;
    idle(1);
    booth_done = 1'b0;
    chk("t4_cnt_two", 32'(term_cnt), 32'd2);
    chk("t4_valid_low", 32'(acc_valid), 32'h0);
    idle(4);
    strobe(8'h00); idle(4);
    exp_q.push_back('{y: 16'h0008, ovf: 1'b0});
    strobe(8'h00); idle(4);

    // 6b. asynchronous reset mid-group
    strobe(8'h05); idle(4);
    strobe(8'h05); idle(4);
    chk("t6_cnt_mid", 32'(term_cnt), 32'd2);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("t6_async_cnt", 32'(term_cnt), 32'd0);
    chk("t6_async_acc_y", 32'(acc_y), 32'h0);
    chk("t6_async_valid", 32'(acc_valid), 32'h0);
    chk("t6_async_ovf", 32'(ovf), 32'h0);
    idle(2);
    rst = 1'b1;
    idle(2);

    // sign-extension extremes at 16 bits
    strobe(8'h80); idle(4);
    strobe(8'h80); idle(4);
    strobe(8'h80); idle(4);
    exp_q.push_back('{y: 16'hFE00, ovf: 1'b0});
    strobe(8'h80); idle(4);
    strobe(8'h7F); idle(4);
    strobe(8'h7F); idle(4);
    strobe(8'h7F); idle(4);
    exp_q.push_back('{y: 16'h01FC, ovf: 1'b0});
    strobe(8'h7F); idle(4);

    // 5. overflow at ACC_W=9: 4 * 64 = 256 exceeds +255
    strobe9(8'h40); idle(4);
    strobe9(8'h40); idle(4);
    strobe9(8'h40);
    chk("t5_cnt3", 32'(term_cnt1), 32'd3);
    chk("t5_no_ovf_yet", 32'(ovf1), 32'h0);
    idle(4);
    strobe9(8'h40);
    chk("t5_valid", 32'(acc_valid1), 32'h1);
`ifdef BOOTH_ACC_SAT_EN
    chk("t5_acc_y_sat", 32'(acc_y1), 32'h0FF);
`else
    chk("t5_acc_y_wrap", 32'(acc_y1), 32'h100);
`endif
    chk("t5_ovf", 32'(ovf1), 32'h1);
    idle(1);
    chk("t5_ovf_cleared", 32'(ovf1), 32'h0);
    idle(3);
    // 4 * -64 = -256 lands exactly on the 9-bit minimum without overflow
    strobe9(8'hC0); idle(4);
    strobe9(8'hC0); idle(4);
    strobe9(8'hC0); idle(4);
    strobe9(8'hC0);
    chk("t5_min_acc_y", 32'(acc_y1), 32'h100);
    chk("t5_min_ovf", 32'(ovf1), 32'h0);
    idle(4);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
